// File: rtl/eeprom_if.sv
// Bus bundle for the word store: shared address, store/load strobes,
// write data and registered read data.
interface eeprom_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              str;
    logic              ld;
    logic [DATA_W-1:0] d_in;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;

    modport master (output str, output ld, output d_in, output a, input d);
    modport slave  (input str, input ld, input d_in, input a, output d);
endinterface

// File: rtl/eeprom.sv
// 16 x 32 program/constant store with a synchronous write port and a
// registered read port sharing one address; read data holds until next load.
module eeprom #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic   c,
    input  logic   rst,
    eeprom_if.slave bus
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] d_q;

    // Read samples mem before the write lands, giving read-before-write on a
    // shared address. The whole array clears on reset, so it stays in flops.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            d_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (bus.ld) begin
                d_q <= mem[bus.a];
            end
            if (bus.str) begin
                mem[bus.a] <= bus.d_in;
            end
        end
    end

    assign bus.d = d_q;
endmodule

// File: tb/tb_eeprom.sv
// Directed bench for eeprom: a reference memory feeds a queue of expected
// read words, popped and compared one cycle after each load.
module tb_eeprom;
    logic c = 1'b0;
    logic rst;

    eeprom_if #(.DATA_W(32), .ADDR_W(4)) bus ();

    eeprom #(.DATA_W(32), .ADDR_W(4), .DEPTH(16)) dut (
        .c   (c),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 c = ~c;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [16];
    logic [31:0] sb [$];
    logic [31:0] last_d;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < 16; i++) model[i] = '0;
        sb.delete();
        last_d = '0;
    endtask

    // One clock: drive at edge+1, sample at next edge+1.
    task automatic step(input logic s, input logic l, input logic [3:0] addr,
                        input logic [31:0] din, input string tag);
        logic [31:0] exp;
        bus.str  = s;
        bus.ld   = l;
        bus.a    = addr;
        bus.d_in = din;
        if (l) sb.push_back(model[addr]);
        @(posedge c);
        #1;
        if (s) model[addr] = din;
        if (l) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL %s: observed empty scoreboard expected entry", tag);
            end else begin
                exp = sb.pop_front();
                last_d = exp;
                check(tag, bus.d, exp);
            end
        end else begin
            check({tag, "_hold"}, bus.d, last_d);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        bus.str  = 1'b0;
        bus.ld   = 1'b0;
        bus.a    = '0;
        bus.d_in = '0;
        clear_model();
        repeat (2) @(posedge c);
        #1;
        check("reset_d", bus.d, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 32'h0, "reset_read");

        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 4'(i), 32'(i + 1), "fill");
            step(1'b0, 1'b0, 4'(i), 32'h0, "fill_idle");
        end
        for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 4'(i), 32'h0, "readback");
        check("readback_a15", bus.d, 32'h0000_0010);

        step(1'b0, 1'b1, 4'd5, 32'h0, "hold_load");
        check("hold_load_val", bus.d, 32'h6);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd9, 32'h0, "hold_idle");
        step(1'b1, 1'b0, 4'd9, 32'hCAFE_F00D, "hold_write");
        step(1'b0, 1'b0, 4'd9, 32'h0, "hold_after_write");
        check("hold_final", bus.d, 32'h6);

        step(1'b1, 1'b0, 4'd3, 32'hDEAD_BEEF, "coll_pre");
        step(1'b1, 1'b1, 4'd3, 32'h1234_5678, "coll_rbw");
        check("coll_old", bus.d, 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 4'd3, 32'h0, "coll_new");
        check("coll_new_val", bus.d, 32'h1234_5678);

        step(1'b1, 1'b0, 4'd2, 32'hA, "rep_a");
        step(1'b1, 1'b0, 4'd2, 32'hB, "rep_b");
        step(1'b0, 1'b1, 4'd2, 32'h0, "rep_read");
        check("rep_val", bus.d, 32'hB);

        for (int i = 6; i < 10; i++) step(1'b0, 1'b1, 4'(i), 32'h0, "stream");
        #3;
        rst      = 1'b1;
        bus.str  = 1'b1;
        bus.ld   = 1'b1;
        bus.a    = 4'd7;
        bus.d_in = 32'hFFFF_FFFF;
        #1;
        check("async_rst_d", bus.d, 32'h0);
        repeat (2) @(posedge c);
        #1;
        check("rst_ignores_strobes", bus.d, 32'h0);
        clear_model();
        bus.str = 1'b0;
        bus.ld  = 1'b0;
        rst     = 1'b0;
        step(1'b0, 1'b1, 4'd7, 32'h0, "post_rst_a7");
        step(1'b0, 1'b1, 4'd9, 32'h0, "post_rst_a9");
        step(1'b0, 1'b1, 4'd3, 32'h0, "post_rst_a3");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eeprom.md
Name: eeprom

Overview:
- 16-word × 32-bit register-file style storage block (program/constant store) for the video display processor datapath.
- Synchronous write port (store strobe) and registered read port (load strobe), both sharing one 4-bit address.
- Read data is held on the output until the next load or reset.

Parameters:
- DATA_W, 32, width of each stored word and of d_in/d.
- ADDR_W, 4, address width.
- DEPTH, 16, number of words; must equal 2**ADDR_W.

Ports:
- c  input  1  clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- str  input  1  store strobe; writes d_in to mem[a] on the rising edge of c.
- ld  input  1  load strobe; registers mem[a] onto d on the rising edge of c.
- d_in  input  DATA_W  write data.
- a  input  ADDR_W  shared read/write address.
- d  output  DATA_W  registered read data.

Behaviour:
- Storage is DEPTH words of DATA_W bits, indexed by a. Every a value (0..15) is valid, so there is no out-of-range case.
- Reset:
  - rst=1 immediately (asynchronously) forces d to 0 and clears all DEPTH words to 0.
  - While rst is high, str and ld are ignored.
  - Operation resumes on the first rising edge of c after rst falls.
  - Reset mid-operation discards any write or load pending on that edge.
- Write:
  - On a rising edge with rst=0 and str=1, mem[a] <= d_in.
  - With str=0, memory is unchanged.
  - Holding str high for several cycles rewrites the same location each cycle; the last value wins.
- Read:
  - On a rising edge with rst=0 and ld=1, d <= mem[a]. Latency is 1 clock: d becomes valid after the edge at which ld was sampled.
  - With ld=0, d holds its previous value. There is no combinational path from a to d.
- Simultaneous str=1 and ld=1 on the same edge:
  - Read-before-write. d receives the old mem[a] and the memory takes d_in.
  - A following ld returns the new value.
  - The same rule applies whether or not the two addresses coincide, since they share a.
- Back-to-back loads with a changing every cycle: d follows with 1-cycle lag, giving one new word per cycle.
- No handshake, busy flag or write delay; every operation completes in one cycle.
- Inputs are sampled only at rising edges. Changes between edges have no effect.

Test Plan:
- Reset: assert rst for 2 cycles, then pulse ld at a=0..15 -> d=0x00000000 for every address; d=0 immediately when rst rises, even mid-cycle.
- Fill/readback: for i=0..15 write d_in=i+1 at a=i (str=1 for one edge, str=0 for one edge); then hold ld=1 while stepping a=0..15 one per cycle -> one cycle after each step d=i+1 (1..0x10); in particular a=15 reads 0x00000010.
- Hold: after reading a=5 (d=6), drop ld and change a to 9 -> d stays 6 for ≥3 cycles; a further write without ld leaves d unchanged.
- Overwrite/collision: write 0xDEADBEEF to a=3, then in one cycle str=1, ld=1, a=3, d_in=0x12345678 -> d=0xDEADBEEF; next cycle with ld=1 -> d=0x12345678.
- Async reset mid-stream: during a back-to-back read sequence, raise rst between edges -> d=0 without waiting for a clock edge; after release, reading a=7 returns 0 (memory cleared).
- Repeated store: str held high at a=2 with d_in changing 0xA then 0xB over two edges -> a later ld at a=2 gives 0x0000000B.
